// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
//
// Captures the decoded instruction and its forwarded operands for the execute stage. Each rising
// edge performs exactly one action, in priority order:
//   HOLD   (dm_stall)  - all state frozen
//   FLUSH  (do_flush)  - insert a dead slot (all fields zero)
//   BUBBLE (do_hazard) - insert a dead slot and count it
//   LOAD               - capture decode-stage fields
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   f_reg_{ra,rb,rt}_data          forwarded operands (32b)
//   do_hazard, dm_stall, do_flush  pipeline control
//   id_*                           decoded instruction fields
//   xREG2_*                        registered EX-stage copies
//   hold_upstream                  combinational freeze request for PC and IF/ID
//   bubble_count                   saturating count of inserted bubbles
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_reg_ra_data,
  input  logic [31:0] f_reg_rb_data,
  input  logic [31:0] f_reg_rt_data,
  input  logic        do_hazard,
  input  logic        dm_stall,
  input  logic        do_flush,
  input  logic        id_valid,
  input  logic        id_do_dm_read,
  input  logic        id_do_dm_write,
  input  logic        id_do_reg_write,
  input  logic [1:0]  id_select_write_reg,
  input  logic [4:0]  id_write_reg_addr,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_imm_extend,
  input  logic [31:0] id_pc,
  output logic        xREG2_valid,
  output logic        xREG2_do_dm_read,
  output logic        xREG2_do_dm_write,
  output logic        xREG2_do_reg_write,
  output logic [1:0]  xREG2_select_write_reg,
  output logic [4:0]  xREG2_write_reg_addr,
  output logic [3:0]  xREG2_alu_op,
  output logic [31:0] xREG2_ra_data,
  output logic [31:0] xREG2_rb_data,
  output logic [31:0] xREG2_rt_data,
  output logic [31:0] xREG2_imm_extend,
  output logic [31:0] xREG2_pc,
  output logic        hold_upstream,
  output logic [15:0] bubble_count
);

  logic        valid_q, valid_d;
  logic        dm_read_q, dm_read_d;
  logic        dm_write_q, dm_write_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  sel_wr_q, sel_wr_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic act_hold, act_flush, act_bubble;

  assign act_hold   = dm_stall;
  assign act_flush  = !dm_stall && do_flush;
  assign act_bubble = !dm_stall && !do_flush && do_hazard;

  // A flush kills the hazarding instruction, so no freeze is needed in that case.
  assign hold_upstream = dm_stall | (do_hazard & ~do_flush);

  always_comb begin
    valid_d      = valid_q;
    dm_read_d    = dm_read_q;
    dm_write_d   = dm_write_q;
    reg_write_d  = reg_write_q;
    sel_wr_d     = sel_wr_q;
    wr_addr_d    = wr_addr_q;
    alu_op_d     = alu_op_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    rt_d         = rt_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    bubble_cnt_d = bubble_cnt_q;

    if (act_hold) begin
      // keep everything
    end else if (act_flush || act_bubble) begin
      valid_d     = 1'b0;
      dm_read_d   = 1'b0;
      dm_write_d  = 1'b0;
      reg_write_d = 1'b0;
      sel_wr_d    = '0;
      wr_addr_d   = '0;
      alu_op_d    = '0;
      ra_d        = '0;
      rb_d        = '0;
      rt_d        = '0;
      imm_d       = '0;
      pc_d        = '0;
      if (act_bubble && (bubble_cnt_q != 16'hFFFF)) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else begin
      valid_d     = id_valid;
      // An invalid slot must never touch memory or the register file.
      dm_read_d   = id_do_dm_read & id_valid;
      dm_write_d  = id_do_dm_write & id_valid;
      reg_write_d = id_do_reg_write & id_valid;
      sel_wr_d    = id_select_write_reg;
      wr_addr_d   = id_write_reg_addr;
      alu_op_d    = id_alu_op;
      ra_d        = f_reg_ra_data;
      rb_d        = f_reg_rb_data;
      rt_d        = f_reg_rt_data;
      imm_d       = id_imm_extend;
      pc_d        = id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      dm_read_q    <= 1'b0;
      dm_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      sel_wr_q     <= '0;
      wr_addr_q    <= '0;
      alu_op_q     <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      dm_read_q    <= dm_read_d;
      dm_write_q   <= dm_write_d;
      reg_write_q  <= reg_write_d;
      sel_wr_q     <= sel_wr_d;
      wr_addr_q    <= wr_addr_d;
      alu_op_q     <= alu_op_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rt_q         <= rt_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign xREG2_valid            = valid_q;
  assign xREG2_do_dm_read       = dm_read_q;
  assign xREG2_do_dm_write      = dm_write_q;
  assign xREG2_do_reg_write     = reg_write_q;
  assign xREG2_select_write_reg = sel_wr_q;
  assign xREG2_write_reg_addr   = wr_addr_q;
  assign xREG2_alu_op           = alu_op_q;
  assign xREG2_ra_data          = ra_q;
  assign xREG2_rb_data          = rb_q;
  assign xREG2_rt_data          = rt_q;
  assign xREG2_imm_extend       = imm_q;
  assign xREG2_pc               = pc_q;
  assign bubble_count           = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_reg_ra_data, f_reg_rb_data, f_reg_rt_data;
  logic        do_hazard, dm_stall, do_flush;
  logic        id_valid, id_do_dm_read, id_do_dm_write, id_do_reg_write;
  logic [1:0]  id_select_write_reg;
  logic [4:0]  id_write_reg_addr;
  logic [3:0]  id_alu_op;
  logic [31:0] id_imm_extend, id_pc;
  logic        xREG2_valid, xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write;
  logic [1:0]  xREG2_select_write_reg;
  logic [4:0]  xREG2_write_reg_addr;
  logic [3:0]  xREG2_alu_op;
  logic [31:0] xREG2_ra_data, xREG2_rb_data, xREG2_rt_data, xREG2_imm_extend, xREG2_pc;
  logic        hold_upstream;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk                    (clk),
    .rst                    (rst),
    .f_reg_ra_data          (f_reg_ra_data),
    .f_reg_rb_data          (f_reg_rb_data),
    .f_reg_rt_data          (f_reg_rt_data),
    .do_hazard              (do_hazard),
    .dm_stall               (dm_stall),
    .do_flush               (do_flush),
    .id_valid               (id_valid),
    .id_do_dm_read          (id_do_dm_read),
    .id_do_dm_write         (id_do_dm_write),
    .id_do_reg_write        (id_do_reg_write),
    .id_select_write_reg    (id_select_write_reg),
    .id_write_reg_addr      (id_write_reg_addr),
    .id_alu_op              (id_alu_op),
    .id_imm_extend          (id_imm_extend),
    .id_pc                  (id_pc),
    .xREG2_valid            (xREG2_valid),
    .xREG2_do_dm_read       (xREG2_do_dm_read),
    .xREG2_do_dm_write      (xREG2_do_dm_write),
    .xREG2_do_reg_write     (xREG2_do_reg_write),
    .xREG2_select_write_reg (xREG2_select_write_reg),
    .xREG2_write_reg_addr   (xREG2_write_reg_addr),
    .xREG2_alu_op           (xREG2_alu_op),
    .xREG2_ra_data          (xREG2_ra_data),
    .xREG2_rb_data          (xREG2_rb_data),
    .xREG2_rt_data          (xREG2_rt_data),
    .xREG2_imm_extend       (xREG2_imm_extend),
    .xREG2_pc               (xREG2_pc),
    .hold_upstream          (hold_upstream),
    .bubble_count           (bubble_count)
  );

  // All xREG2_* outputs packed in a fixed order (175 bits).
  logic [174:0] obs;
  assign obs = {xREG2_valid, xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write,
                xREG2_select_write_reg, xREG2_write_reg_addr, xREG2_alu_op, xREG2_ra_data,
                xREG2_rb_data, xREG2_rt_data, xREG2_imm_extend, xREG2_pc};

  // Hand-specified instruction image: {valid, rd, wr, rw, sel, addr, alu, ra, rb, rt, imm, pc}.
  function automatic logic [174:0] pack(input logic v, input logic r, input logic w,
                                        input logic rw, input logic [1:0] s, input logic [4:0] a,
                                        input logic [3:0] op, input logic [31:0] ra,
                                        input logic [31:0] rb, input logic [31:0] rt,
                                        input logic [31:0] imm, input logic [31:0] pc);
    return {v, r, w, rw, s, a, op, ra, rb, rt, imm, pc};
  endfunction

  task automatic drive_id(input logic v, input logic r, input logic w, input logic rw,
                          input logic [1:0] s, input logic [4:0] a, input logic [3:0] op,
                          input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rt,
                          input logic [31:0] imm, input logic [31:0] pc);
    id_valid = v; id_do_dm_read = r; id_do_dm_write = w; id_do_reg_write = rw;
    id_select_write_reg = s; id_write_reg_addr = a; id_alu_op = op;
    f_reg_ra_data = ra; f_reg_rb_data = rb; f_reg_rt_data = rt;
    id_imm_extend = imm; id_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dm_stall = 1'b0; do_flush = 1'b0; do_hazard = 1'b0;
    drive_id(1, 1, 1, 1, 2'd3, 5'd31, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); tick();
    n_checks++;
    if (obs !== 175'b0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", obs);
    end
    n_checks++;
    if (bubble_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_count: got %h want 0", bubble_count);
    end
    // hold_upstream stays purely combinational while in reset.
    dm_stall = 1'b1; #1;
    n_checks++;
    if (hold_upstream !== 1'b1) begin
      n_fail++; $display("FAIL reset_hold: got %b want 1", hold_upstream);
    end
    dm_stall = 1'b0; do_hazard = 1'b1; do_flush = 1'b1; #1;
    n_checks++;
    if (hold_upstream !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_flush: got %b want 0", hold_upstream);
    end
    do_hazard = 1'b0; do_flush = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load();
    drive_id(1, 0, 0, 1, 2'd1, 5'd5, 4'h3, 32'h1234_5678, 32'hCAFE_0001, 32'h0BAD_F00D,
             32'h0000_0010, 32'h0000_0100);
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 0, 1, 2'd1, 5'd5, 4'h3, 32'h1234_5678, 32'hCAFE_0001, 32'h0BAD_F00D,
                     32'h0000_0010, 32'h0000_0100)) begin
      n_fail++; $display("FAIL load_basic: got %h", obs);
    end
    n_checks++;
    if (hold_upstream !== 1'b0) begin
      n_fail++; $display("FAIL load_hold: got %b want 0", hold_upstream);
    end
    // Invalid slot: enables masked, other fields still captured.
    drive_id(0, 1, 1, 1, 2'd2, 5'd9, 4'hA, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
             32'h4444_4444, 32'h5555_5555);
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 0, 0, 2'd2, 5'd9, 4'hA, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                     32'h4444_4444, 32'h5555_5555)) begin
      n_fail++; $display("FAIL load_invalid: got %h", obs);
    end
    n_checks++;
    if (bubble_count !== 16'h0) begin
      n_fail++; $display("FAIL load_count: got %h want 0", bubble_count);
    end
  endtask

  task automatic test_load_use();
    // Producer load enters EX.
    drive_id(1, 1, 0, 1, 2'd2, 5'd7, 4'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h4, 32'h0000_0200);
    tick();
    // Dependent instruction sits in ID with a hazard.
    drive_id(1, 0, 0, 1, 2'd0, 5'd8, 4'h2, 32'hAAAA_0000, 32'h0000_BBBB, 32'h0, 32'h0,
             32'h0000_0204);
    do_hazard = 1'b1; #1;
    n_checks++;
    if (hold_upstream !== 1'b1) begin
      n_fail++; $display("FAIL lu_hold: got %b want 1", hold_upstream);
    end
    tick();
    n_checks++;
    if (obs !== 175'b0) begin
      n_fail++; $display("FAIL lu_bubble: got %h want 0", obs);
    end
    n_checks++;
    if (bubble_count !== 16'd1) begin
      n_fail++; $display("FAIL lu_count: got %h want 1", bubble_count);
    end
    do_hazard = 1'b0; #1;
    n_checks++;
    if (hold_upstream !== 1'b0) begin
      n_fail++; $display("FAIL lu_release: got %b want 0", hold_upstream);
    end
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 0, 1, 2'd0, 5'd8, 4'h2, 32'hAAAA_0000, 32'h0000_BBBB, 32'h0, 32'h0,
                     32'h0000_0204)) begin
      n_fail++; $display("FAIL lu_reload: got %h", obs);
    end
    n_checks++;
    if (bubble_count !== 16'd1) begin
      n_fail++; $display("FAIL lu_count_after: got %h want 1", bubble_count);
    end
  endtask

  task automatic test_flush_vs_hazard();
    drive_id(1, 0, 1, 0, 2'd1, 5'd3, 4'h5, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0000_0300);
    do_flush = 1'b1; do_hazard = 1'b1; #1;
    n_checks++;
    if (hold_upstream !== 1'b0) begin
      n_fail++; $display("FAIL fh_hold: got %b want 0", hold_upstream);
    end
    tick();
    n_checks++;
    if (obs !== 175'b0) begin
      n_fail++; $display("FAIL fh_fields: got %h want 0", obs);
    end
    n_checks++;
    if (bubble_count !== 16'd1) begin
      n_fail++; $display("FAIL fh_count: got %h want 1", bubble_count);
    end
    do_flush = 1'b0; do_hazard = 1'b0;
  endtask

  task automatic test_stall();
    logic [174:0] held;
    drive_id(1, 0, 0, 1, 2'd3, 5'd12, 4'h6, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF,
             32'hFFFF_FFF0, 32'h0000_0400);
    tick();
    held = pack(1, 0, 0, 1, 2'd3, 5'd12, 4'h6, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF,
                32'hFFFF_FFF0, 32'h0000_0400);
    dm_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 1, 1, 1, 2'(i), 5'(20 + i), 4'(9 + i), 32'(i), 32'(i + 1), 32'(i + 2),
               32'(i + 3), 32'(i + 4));
      do_hazard = (i == 1); do_flush = (i == 2); #1;
      n_checks++;
      if (hold_upstream !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b want 1", i, hold_upstream);
      end
      tick();
      n_checks++;
      if (obs !== held || bubble_count !== 16'd1) begin
        n_fail++; $display("FAIL stall_frozen[%0d]: got %h cnt %h", i, obs, bubble_count);
      end
    end
    // Stall released with flush still asserted: flush applies now.
    dm_stall = 1'b0; do_hazard = 1'b0; do_flush = 1'b1;
    tick();
    n_checks++;
    if (obs !== 175'b0 || bubble_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_then_flush: got %h cnt %h", obs, bubble_count);
    end
    do_flush = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_id(1, 0, 0, 1, 2'd1, 5'd17, 4'h4, 32'h7777_7777, 32'h8, 32'h9, 32'hA, 32'h0000_0500);
    tick();
    n_checks++;
    if (xREG2_valid !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre_valid: got %b want 1", xREG2_valid);
    end
    #2; rst = 1'b1; #1;
    n_checks++;
    if (obs !== 175'b0 || bubble_count !== 16'd0) begin
      n_fail++; $display("FAIL ar_async_clear: got %h cnt %h", obs, bubble_count);
    end
    #1; rst = 1'b0;
    drive_id(1, 0, 1, 0, 2'd2, 5'd21, 4'h8, 32'hABCD_0001, 32'hABCD_0002, 32'hABCD_0003,
             32'hABCD_0004, 32'h0000_0600);
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 0, 2'd2, 5'd21, 4'h8, 32'hABCD_0001, 32'hABCD_0002, 32'hABCD_0003,
                     32'hABCD_0004, 32'h0000_0600)) begin
      n_fail++; $display("FAIL ar_reload: got %h", obs);
    end
  endtask

  task automatic test_saturation();
    // Counter starts at 0 after the previous reset; run up to 16'hFFFE.
    do_hazard = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (bubble_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_preload: got %h want fffe", bubble_count);
    end
    tick();
    n_checks++;
    if (bubble_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_max: got %h want ffff", bubble_count);
    end
    tick();
    n_checks++;
    if (bubble_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_stay: got %h want ffff", bubble_count);
    end
    do_hazard = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_use();
    test_flush_vs_hazard();
    test_stall();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
